vector_lane_sequencer: RTL
==========================

# vector_lane_sequencer

Sequencer that accepts one packed vector of up to eight signed bytes and streams its lanes one per cycle to a shared single-lane datapath (adder/multiplier stage) over a valid/ready handshake. It also accumulates a signed running sum of the streamed lanes and reports it after the last lane. It sits between the vector producer and the byte-wide processing element. It applies the same lane selection rules as the vector unpacking logic, including the odd-length rule.

## Interface
- NB_DATA, 8, lane width in bits.
- N_LENGTH_DATA, 8, number of lanes streamed per vector; legal range 1..8.
- ORDER, 0, stream order: 0 = lane 0 first, 1 = lane N_LENGTH_DATA-1 first.

- clock  input  1  single clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_data  input  8*NB_DATA  packed vector; lane k = i_data[(k+1)*NB_DATA-1 -: NB_DATA].
- i_valid  input  1  vector present on i_data.
- o_ready  output  1  sequencer can accept a vector.
- i_clear  input  1  synchronous abort; drops the current vector.
- o_data  output  NB_DATA  current lane, signed.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream accepts o_data.
- o_last  output  1  current o_data is the final lane of the vector.
- o_sum  output  NB_DATA+3  signed sum of all lanes of the last completed vector.
- o_sum_valid  output  1  one-cycle pulse when o_sum updates.

## Operation
- Lane selection at capture:
  - If N_LENGTH_DATA is even, stored lane k = input lane k, for k = 0..N-1.
  - If N_LENGTH_DATA is odd, stored lanes 0..N-2 = input lanes 0..N-2, and stored lane N-1 = input lane 7 (i_data[8*NB_DATA-1 -: NB_DATA]).
  - Input lanes that are not selected are ignored.
- FSM states: IDLE, STREAM, SUM.
  - IDLE: o_ready=1. On i_valid=1, capture the selected lanes into the lane bank, set cnt=0 and acc=0, and go to STREAM.
  - STREAM: o_valid=1 and o_data=bank[idx]. idx=cnt when ORDER=0; idx=N-1-cnt when ORDER=1. o_last=1 when cnt==N-1.
    - On i_ready=1: acc += sign-extended o_data and cnt++.
    - If cnt==N-1 at that handshake, go to SUM.
    - On i_ready=0: o_data, o_valid, o_last and cnt hold.
  - SUM: o_sum <= acc (already including the last lane), o_sum_valid=1 for this cycle only, then go to IDLE.
- o_ready=0 in STREAM and SUM. i_valid is ignored outside IDLE.
- Arithmetic: lanes are two's complement. acc and o_sum are NB_DATA+3 bits, so eight lanes cannot overflow: range -8*2^(NB_DATA-1) .. 8*(2^(NB_DATA-1)-1).
- o_sum holds its value between SUM pulses.
- i_clear=1 (any state): next state is IDLE, cnt and acc are cleared, no o_sum_valid pulse, and o_sum keeps its previous value.
  - i_clear has priority over i_valid and over the handshake in the same cycle.
- N_LENGTH_DATA=1: STREAM lasts exactly one accepted beat with o_last=1.

## Timing
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_ready=1, o_valid=0, o_last=0, o_data=0, o_sum=0, o_sum_valid=0, cnt=0, acc=0.
  - Reset mid-stream abandons the vector immediately.
  - Release is synchronous to clock.
- Capture at edge T (i_valid && o_ready). First o_valid=1 during cycle T+1.
- With i_ready held at 1: lanes occupy cycles T+1..T+N and o_sum_valid is high in cycle T+N+1. The next vector can be captured at the edge closing cycle T+N+2, since o_ready=1 from T+N+2.
- Minimum vector period is N+2 cycles. Each cycle with i_ready=0 in STREAM adds one cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from i_ready or i_valid to any output.

## Test plan
- N=8, ORDER=0, lanes 0x01..0x08, i_ready=1 -> o_data 01..08 in cycles T+1..T+8, o_last only at 08, o_sum=36 with o_sum_valid in cycle T+9, o_ready=1 in T+10.
- N=8, all lanes 0x80 -> o_sum=-1024 (11'h400); all lanes 0x7F -> o_sum=1016 (11'h3F8).
- N=3, lanes0..2 = 0x11,0x22,0x55, lane7=0x33 -> stream 11,22,33 (0x55 ignored), o_sum=0x66.
- N=8, ORDER=1, lanes 0x01..0x08, i_ready low for 2 cycles after the third beat -> stream 08,07,06, then o_data=05 held with o_valid=1 for 2 extra cycles, then 05..01, o_sum=36.
- i_clear asserted on the fourth beat, and separately i_rst_n pulsed low mid-stream -> next cycle IDLE, o_valid=0, no o_sum_valid; after reset o_sum=0, after clear o_sum keeps its prior value.
- i_valid held high continuously with N=2 -> captures exactly every 4 cycles; i_valid during STREAM/SUM has no effect.

Source files
------------

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: captures one packed vector of signed lanes, streams
// them one per cycle over valid/ready, and reports the signed lane sum.
module vector_lane_sequencer #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned N_LENGTH_DATA = 8,
  parameter int unsigned ORDER         = 0
) (
  input  logic                   clock,
  input  logic                   i_rst_n,
  input  logic [8*NB_DATA-1:0]   i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_clear,
  output logic [NB_DATA-1:0]     o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic [NB_DATA+2:0]     o_sum,
  output logic                   o_sum_valid
);

  localparam int unsigned SUM_W = NB_DATA + 3;
  localparam int unsigned EXT_W = SUM_W - NB_DATA;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LENGTH_DATA - 1);
  localparam bit ODD_LEN = ((N_LENGTH_DATA % 2) == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SUM    = 2'd2
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SUM_W-1:0]     acc_q;
  logic [SUM_W-1:0]     acc_d;
  logic [NB_DATA-1:0]   bank_q [N_LENGTH_DATA];
  logic [NB_DATA-1:0]   sel_c  [N_LENGTH_DATA];
  logic                 ready_q;
  logic                 valid_q;
  logic                 last_q;
  logic [NB_DATA-1:0]   data_q;
  logic [SUM_W-1:0]     sum_q;
  logic                 sum_valid_q;

  // Stream position to bank slot, honouring the configured order
  function automatic logic [CNT_W-1:0] lane_idx(input logic [CNT_W-1:0] c);
    if (ORDER == 1) return LAST_CNT - c;
    return c;
  endfunction

  // Lane selection at capture: odd lengths take their final lane from input lane 7
  always_comb begin
    for (int unsigned k = 0; k < N_LENGTH_DATA; k++) begin
      sel_c[k] = i_data[k*NB_DATA +: NB_DATA];
      if (ODD_LEN && (k == N_LENGTH_DATA - 1)) begin
        sel_c[k] = i_data[7*NB_DATA +: NB_DATA];
      end
    end
  end

  // Running sum including the lane currently on o_data
  assign acc_d = acc_q + {{EXT_W{data_q[NB_DATA-1]}}, data_q};

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      for (int unsigned k = 0; k < N_LENGTH_DATA; k++) begin
        bank_q[k] <= '0;
      end
    end else if (i_clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            for (int unsigned k = 0; k < N_LENGTH_DATA; k++) begin
              bank_q[k] <= sel_c[k];
            end
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= sel_c[lane_idx('0)];
            valid_q <= 1'b1;
            last_q  <= (LAST_CNT == '0);
            ready_q <= 1'b0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (i_ready) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              sum_q       <= acc_d;
              sum_valid_q <= 1'b1;
              state_q     <= SUM;
            end else begin
              data_q <= bank_q[lane_idx(cnt_q + CNT_W'(1))];
              last_q <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
            end
          end
        end
        SUM: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_last      = last_q;
  assign o_data      = data_q;
  assign o_sum       = sum_q;
  assign o_sum_valid = sum_valid_q;

endmodule
